bmp_frame_ram: RTL and testbench
================================

Name: bmp_frame_ram

Overview:
- Parametrised byte-addressed frame buffer for a complete BMP file image (header, palette and pixel array).
- Sits between the BMP loader, which streams file bytes in, and the image-processing stages, which read pixels out.
- Adds the following:
  - a synchronous read port with valid handshake;
  - a hardware clear sweep, so no simulation-only initialisation is needed;
  - on-the-fly capture of the BMP header fields;
  - address-range checking and a write counter.

Parameters:
- DATA_WIDTH, 8: bits per memory word (one file byte).
- DEPTH, 263222: memory words. Default is a 512x512 8-bit grey BMP: 54 header + 1024 palette + 262144 pixels.
- ADDR_WIDTH, 19: address bits; must satisfy 2^ADDR_WIDTH >= DEPTH.
- HDR_BYTES, 30: number of leading bytes treated as the header capture window.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- clr_start  in  1  one-cycle pulse that re-enters CLEAR from READY.
- RAM_valid  in  1  write strobe.
- in_addr  in  ADDR_WIDTH  write address.
- in_data  in  DATA_WIDTH  write data.
- wr_ready  out  1  high in READY; writes are accepted only when RAM_valid && wr_ready.
- rd_req  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_valid  out  1  read data valid, exactly one cycle after rd_req.
- rd_data  out  DATA_WIDTH  read data.
- hdr_valid  out  1  all HDR_BYTES header bytes have been written since the last clear.
- sig_ok  out  1  bytes 0/1 equal 0x42/0x4D ("BM").
- pix_offset  out  32  little-endian bytes 10..13.
- img_width  out  32  little-endian bytes 18..21.
- img_height  out  32  little-endian bytes 22..25.
- bpp  out  16  little-endian bytes 28..29.
- wr_count  out  ADDR_WIDTH+1  accepted in-range writes since the last clear; saturates at DEPTH.
- addr_err  out  1  sticky; set by any out-of-range write or read.

Behaviour:
- Reset (rst_n=0 sampled at posedge):
  - state goes to CLEAR and the clear counter to 0;
  - every output is 0: wr_ready, rd_valid, rd_data, hdr_valid, sig_ok, all header fields, wr_count, addr_err.
  - Reset asserted mid-clear or mid-load restarts the sweep from address 0.
- FSM, states CLEAR and READY:
  - CLEAR: writes 0 to address clr_cnt each cycle, clr_cnt = 0..DEPTH-1.
    - Moves to READY on the cycle after writing address DEPTH-1.
    - wr_ready first rises DEPTH cycles after rst_n deasserts.
    - RAM_valid is ignored. rd_req is still serviced: rd_valid=1, rd_data=0.
  - READY: wr_ready=1.
    - clr_start=1 moves to CLEAR the next cycle.
    - A write presented in the same cycle as clr_start is still performed.
    - Entering CLEAR zeroes the header registers, the header mask, wr_count and addr_err.
- Write (READY, RAM_valid=1):
  - in_addr < DEPTH: memory is updated at the posedge and wr_count increments, saturating at DEPTH.
  - in_addr >= DEPTH: the write is dropped and addr_err is set.
- Header capture:
  - A write with in_addr < HDR_BYTES sets mask bit in_addr.
  - If the address lies in a field's byte range, that byte of the field register is updated in the same cycle.
  - Rewriting a header byte overwrites the field byte.
  - hdr_valid = &mask (registered, valid the cycle after the last missing byte is written).
  - sig_ok is derived from the captured bytes 0/1 and is only meaningful when hdr_valid=1.
- Read:
  - Latency 1: rd_req at cycle N gives rd_valid=1 and rd_data at cycle N+1.
  - rd_valid=0 otherwise; rd_data holds its last value.
  - Back-to-back reads are fully pipelined, one per cycle.
  - rd_addr >= DEPTH returns rd_data=0 and sets addr_err.
- Read and write to the same address in the same cycle: read-before-write, so rd_data returns the old contents.
- All arithmetic is unsigned. No address wrap-around: out-of-range accesses never alias.

Decomposition:
- DEFINE.vh holds:
  - BYTE_WIDTH and BMP_TOTAL_SIZE (used as parameter defaults);
  - header offsets BMP_OFF_SIG=0, BMP_OFF_PIXOFS=10, BMP_OFF_WIDTH=18, BMP_OFF_HEIGHT=22, BMP_OFF_BPP=28;
  - state encodings ST_CLEAR and ST_READY.
- Sub-module bmp_dp_ram: simple dual-port RAM with one write port, one registered read port, read-before-write, no reset on the array.
- The top level owns the FSM, clear write-mux, header capture, counters and error logic.

Test Plan:
- Clear after reset: DEPTH=64, release rst_n → wr_ready=0 for exactly 64 cycles then 1; reading all 64 addresses returns 0x00.
- Load and readback: write bytes addr 0..63 with data=addr^0xA5, then rd_req addr 0..63 back-to-back → rd_valid each next cycle, data matches; wr_count=64.
- Header capture: write a 54-byte header with "BM", offset 0x436, width 0x200, height 0x200, bpp 8, writing bytes in reverse order → hdr_valid rises only after byte 0 is written; sig_ok=1, pix_offset=1078, img_width=512, img_height=512, bpp=8.
- Collision and range: write 0x11 then, in one cycle, write 0x22 and read the same address → rd_data=0x11, then a later read returns 0x22. Write to addr 64 (DEPTH=64) → dropped and addr_err=1. Read of addr 70 → rd_data=0.
- Mid-operation reset and reclear: assert rst_n=0 at clear cycle 30 → the sweep restarts and wr_ready rises 64 cycles after release. In READY, pulse clr_start → hdr_valid, wr_count and addr_err go to 0 and memory reads as 0 after the sweep.

Source files
------------

// File: rtl/bmp_frame_ram_pkg.sv
// Shared constants for the BMP frame buffer: default sizes, header field
// byte offsets and the controller state type.
package bmp_frame_ram_pkg;

  localparam int unsigned BYTE_WIDTH     = 8;
  localparam int unsigned BMP_TOTAL_SIZE = 263222;

  localparam int unsigned BMP_OFF_SIG    = 0;
  localparam int unsigned BMP_OFF_PIXOFS = 10;
  localparam int unsigned BMP_OFF_WIDTH  = 18;
  localparam int unsigned BMP_OFF_HEIGHT = 22;
  localparam int unsigned BMP_OFF_BPP    = 28;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// File: rtl/bmp_frame_ram_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and a write to the same word in one cycle return the old contents.
// The array has no reset; the top level clears it with a sweep.
module bmp_dp_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned IDX_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write and read share the edge; nonblocking update gives read-before-write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bmp_frame_ram.sv
// BMP frame buffer: clear sweep controller, write/read ports with range
// checking, on-the-fly header field capture and accepted-write counter.
module bmp_frame_ram
  import bmp_frame_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BYTE_WIDTH,
  parameter int unsigned DEPTH      = BMP_TOTAL_SIZE,
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned HDR_BYTES  = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_start,
  input  logic                  RAM_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  wr_ready,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  hdr_valid,
  output logic                  sig_ok,
  output logic [31:0]           pix_offset,
  output logic [31:0]           img_width,
  output logic [31:0]           img_height,
  output logic [15:0]           bpp,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  addr_err
);

  localparam int unsigned           IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_zero_q, rd_zero_d;
  logic [HDR_BYTES-1:0]  mask_q, mask_d;
  logic                  hdr_valid_q, hdr_valid_d;
  logic [15:0]           sig_q, sig_d;
  logic                  sig_ok_q, sig_ok_d;
  logic [31:0]           pix_offset_q, pix_offset_d;
  logic [31:0]           img_width_q, img_width_d;
  logic [31:0]           img_height_q, img_height_d;
  logic [15:0]           bpp_q, bpp_d;
  logic [ADDR_WIDTH:0]   wr_count_q, wr_count_d;
  logic                  addr_err_q, addr_err_d;

  logic                  wr_in_range, rd_in_range, wr_acc, wr_bad, rd_bad, enter_clr;
  logic [BYTE_WIDTH-1:0] wr_byte;
  logic                  ram_we, ram_re;
  logic [IDX_WIDTH-1:0]  ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

  assign wr_in_range = {1'b0, in_addr} < DEPTH_C;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_C;
  assign wr_acc      = (state_q == ST_READY) && RAM_valid && wr_in_range;
  assign wr_bad      = (state_q == ST_READY) && RAM_valid && !wr_in_range;
  assign rd_bad      = rd_req && !rd_in_range;
  assign enter_clr   = (state_q == ST_READY) && clr_start;
  assign wr_byte     = in_data[BYTE_WIDTH-1:0];

  // RAM port muxing: the sweep owns the write port while clearing.
  always_comb begin
    ram_we    = wr_acc;
    ram_waddr = in_addr[IDX_WIDTH-1:0];
    ram_wdata = in_data;
    if (state_q == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt_q[IDX_WIDTH-1:0];
      ram_wdata = '0;
    end
    ram_re = rd_req && rd_in_range && (state_q == ST_READY);
  end

  // Next-state: FSM, header capture, counters and error flag.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    mask_d       = mask_q;
    sig_d        = sig_q;
    pix_offset_d = pix_offset_q;
    img_width_d  = img_width_q;
    img_height_d = img_height_q;
    bpp_d        = bpp_q;
    wr_count_d   = wr_count_q;
    addr_err_d   = addr_err_q;
    rd_valid_d   = rd_req;
    rd_zero_d    = rd_zero_q;

    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_READY;
          clr_cnt_d = '0;
        end
      end
      default: begin
        clr_cnt_d = '0;
        if (clr_start) begin
          state_d = ST_CLEAR;
        end
      end
    endcase

    if (wr_acc) begin
      if (wr_count_q != DEPTH_C) begin
        wr_count_d = wr_count_q + 1'b1;
      end
      for (int unsigned i = 0; i < HDR_BYTES; i++) begin
        if (in_addr == ADDR_WIDTH'(i)) mask_d[i] = 1'b1;
      end
      for (int unsigned k = 0; k < 4; k++) begin
        if (in_addr == ADDR_WIDTH'(BMP_OFF_PIXOFS + k)) pix_offset_d[8*k +: 8] = wr_byte;
        if (in_addr == ADDR_WIDTH'(BMP_OFF_WIDTH + k))  img_width_d[8*k +: 8]  = wr_byte;
        if (in_addr == ADDR_WIDTH'(BMP_OFF_HEIGHT + k)) img_height_d[8*k +: 8] = wr_byte;
      end
      for (int unsigned k = 0; k < 2; k++) begin
        if (in_addr == ADDR_WIDTH'(BMP_OFF_SIG + k)) sig_d[8*k +: 8] = wr_byte;
        if (in_addr == ADDR_WIDTH'(BMP_OFF_BPP + k)) bpp_d[8*k +: 8] = wr_byte;
      end
    end

    if (wr_bad || rd_bad) begin
      addr_err_d = 1'b1;
    end

    // Zeroing on clear entry wins over any capture/flag set in the same cycle.
    if (enter_clr) begin
      mask_d       = '0;
      sig_d        = '0;
      pix_offset_d = '0;
      img_width_d  = '0;
      img_height_d = '0;
      bpp_d        = '0;
      wr_count_d   = '0;
      addr_err_d   = 1'b0;
    end

    if (rd_req) begin
      rd_zero_d = (state_q == ST_CLEAR) || !rd_in_range;
    end

    wr_ready_d  = (state_d == ST_READY);
    hdr_valid_d = &mask_d;
    sig_ok_d    = (sig_d == 16'h4D42);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= '0;
      wr_ready_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_zero_q    <= 1'b1;
      mask_q       <= '0;
      hdr_valid_q  <= 1'b0;
      sig_q        <= '0;
      sig_ok_q     <= 1'b0;
      pix_offset_q <= '0;
      img_width_q  <= '0;
      img_height_q <= '0;
      bpp_q        <= '0;
      wr_count_q   <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      wr_ready_q   <= wr_ready_d;
      rd_valid_q   <= rd_valid_d;
      rd_zero_q    <= rd_zero_d;
      mask_q       <= mask_d;
      hdr_valid_q  <= hdr_valid_d;
      sig_q        <= sig_d;
      sig_ok_q     <= sig_ok_d;
      pix_offset_q <= pix_offset_d;
      img_width_q  <= img_width_d;
      img_height_q <= img_height_d;
      bpp_q        <= bpp_d;
      wr_count_q   <= wr_count_d;
      addr_err_q   <= addr_err_d;
    end
  end

  bmp_dp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(rd_addr[IDX_WIDTH-1:0]),
    .rdata(ram_rdata)
  );

  // Reads during a clear or out of range return zero; both sources only
  // change on a request, so rd_data holds between requests.
  assign rd_data    = rd_zero_q ? '0 : ram_rdata;
  assign wr_ready   = wr_ready_q;
  assign rd_valid   = rd_valid_q;
  assign hdr_valid  = hdr_valid_q;
  assign sig_ok     = sig_ok_q;
  assign pix_offset = pix_offset_q;
  assign img_width  = img_width_q;
  assign img_height = img_height_q;
  assign bpp        = bpp_q;
  assign wr_count   = wr_count_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_bmp_frame_ram.sv
// Scoreboard bench for bmp_frame_ram with a small DEPTH and a byte-array model.
module tb_bmp_frame_ram;

  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 7;
  localparam int HB    = 30;

  logic          clk = 1'b0;
  logic          rst_n, clr_start, RAM_valid, rd_req;
  logic [AW-1:0] in_addr, rd_addr;
  logic [DW-1:0] in_data;
  logic          wr_ready, rd_valid, hdr_valid, sig_ok, addr_err;
  logic [DW-1:0] rd_data;
  logic [31:0]   pix_offset, img_width, img_height;
  logic [15:0]   bpp;
  logic [AW:0]   wr_count;

  always #5 clk = ~clk;

  bmp_frame_ram #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(AW),
    .HDR_BYTES (HB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_start (clr_start),
    .RAM_valid (RAM_valid),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .wr_ready  (wr_ready),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .hdr_valid (hdr_valid),
    .sig_ok    (sig_ok),
    .pix_offset(pix_offset),
    .img_width (img_width),
    .img_height(img_height),
    .bpp       (bpp),
    .wr_count  (wr_count),
    .addr_err  (addr_err)
  );

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  // Reference model: file bytes as written, plus counters and flags.
  logic [7:0] mem_m [DEPTH];
  int         cnt_m;
  bit         err_m;
  bit [HB-1:0] mask_m;
  bit         ready_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle, rd_valid must match the scoreboard; data on a hit.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      check("rd_valid", {31'b0, rd_valid}, 32'd1);
      check("rd_data", {24'b0, rd_data}, {24'b0, mon_e.data});
    end else begin
      check("rd_valid_idle", {31'b0, rd_valid}, 32'd0);
    end
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    cnt_m  = 0;
    err_m  = 1'b0;
    mask_m = '0;
  endtask

  task automatic cycle(input bit wr, input int wa, input int wd,
                       input bit rd, input int ra, input bit clr);
    exp_t e;
    RAM_valid = wr;
    in_addr   = AW'(wa);
    in_data   = DW'(wd);
    rd_req    = rd;
    rd_addr   = AW'(ra);
    clr_start = clr;
    if (rd) begin
      e.cyc  = cyc + 1;
      e.data = (ra < DEPTH) ? mem_m[ra] : 8'h00;
      sb.push_back(e);
      if (ra >= DEPTH) err_m = 1'b1;
    end
    if (wr && ready_m) begin
      if (wa < DEPTH) begin
        mem_m[wa] = 8'(wd);
        if (cnt_m < DEPTH) cnt_m++;
        if (wa < HB) mask_m[wa] = 1'b1;
      end else begin
        err_m = 1'b1;
      end
    end
    if (clr && ready_m) begin
      ready_m = 1'b0;
      model_clear();
    end
    @(negedge clk);
    RAM_valid = 1'b0;
    rd_req    = 1'b0;
    clr_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (wr_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, n, DEPTH);
    ready_m = (wr_ready === 1'b1);
  endtask

  task automatic do_reset(input int ncyc);
    rst_n   = 1'b0;
    ready_m = 1'b0;
    model_clear();
    repeat (ncyc) @(negedge clk);
    check("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
    check("rst_rd_data", {24'b0, rd_data}, 32'd0);
    check("rst_hdr_valid", {31'b0, hdr_valid}, 32'd0);
    check("rst_sig_ok", {31'b0, sig_ok}, 32'd0);
    check("rst_fields", pix_offset | img_width | img_height | {16'b0, bpp}, 32'd0);
    check("rst_wr_count", {24'b0, wr_count}, 32'd0);
    check("rst_addr_err", {31'b0, addr_err}, 32'd0);
    rst_n = 1'b1;
    wait_ready("reset_sweep_len");
  endtask

  task automatic check_state(input string tag);
    check({tag, "_wr_count"}, {24'b0, wr_count}, cnt_m);
    check({tag, "_addr_err"}, {31'b0, addr_err}, {31'b0, err_m});
    check({tag, "_hdr_valid"}, {31'b0, hdr_valid}, {31'b0, &mask_m});
    check({tag, "_sig_ok"}, {31'b0, sig_ok}, {31'b0, (mem_m[0] == 8'h42 && mem_m[1] == 8'h4D)});
    check({tag, "_pix_offset"}, pix_offset, {mem_m[13], mem_m[12], mem_m[11], mem_m[10]});
    check({tag, "_img_width"}, img_width, {mem_m[21], mem_m[20], mem_m[19], mem_m[18]});
    check({tag, "_img_height"}, img_height, {mem_m[25], mem_m[24], mem_m[23], mem_m[22]});
    check({tag, "_bpp"}, {16'b0, bpp}, {16'b0, mem_m[29], mem_m[28]});
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 0, 0, 1'b1, i, 1'b0);
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hdr [54];
    logic [31:0] v;

    rst_n = 1'b0; clr_start = 1'b0; RAM_valid = 1'b0; rd_req = 1'b0;
    in_addr = '0; rd_addr = '0; in_data = '0;
    @(negedge clk);

    // Reset, sweep length, cleared contents
    do_reset(3);
    read_all();

    // Load addr^A5 then pipelined readback
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, i, i ^ 'hA5, 1'b0, 0, 1'b0);
    read_all();
    check("load_wr_count_full", {24'b0, wr_count}, DEPTH);
    check_state("load");

    // Clear sweep from READY
    cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
    check("clr_wr_ready", {31'b0, wr_ready}, 32'd0);
    check("clr_hdr_valid", {31'b0, hdr_valid}, 32'd0);
    check("clr_wr_count", {24'b0, wr_count}, 32'd0);
    wait_ready("clr_sweep_len");
    read_all();

    // Header written in reverse order
    for (int i = 0; i < 54; i++) hdr[i] = 8'($urandom_range(0, 255));
    hdr[0] = 8'h42;
    hdr[1] = 8'h4D;
    for (int k = 0; k < 4; k++) begin
      v = 32'h436 >> (8 * k); hdr[10 + k] = v[7:0];
      v = 32'h200 >> (8 * k); hdr[18 + k] = v[7:0];
      v = 32'h200 >> (8 * k); hdr[22 + k] = v[7:0];
    end
    hdr[28] = 8'd8;
    hdr[29] = 8'd0;
    for (int i = 53; i >= 0; i--) begin
      cycle(1'b1, i, int'(hdr[i]), 1'b0, 0, 1'b0);
      check("hdr_valid_progress", {31'b0, hdr_valid}, {31'b0, &mask_m});
    end
    check("hdr_sig_ok", {31'b0, sig_ok}, 32'd1);
    check("hdr_pix_offset", pix_offset, 32'd1078);
    check("hdr_img_width", img_width, 32'd512);
    check("hdr_img_height", img_height, 32'd512);
    check("hdr_bpp", {16'b0, bpp}, 32'd8);
    check_state("hdr");

    // Same-cycle collision and range errors
    cycle(1'b1, 40, 'h11, 1'b0, 0, 1'b0);
    cycle(1'b1, 40, 'h22, 1'b1, 40, 1'b0);
    cycle(1'b0, 0, 0, 1'b1, 40, 1'b0);
    cycle(1'b1, 64, 'h77, 1'b0, 0, 1'b0);
    check("range_wr_err", {31'b0, addr_err}, 32'd1);
    cycle(1'b0, 0, 0, 1'b1, 70, 1'b0);
    idle(2);
    check_state("range");

    cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
    wait_ready("clr2_sweep_len");
    check("clr2_addr_err", {31'b0, addr_err}, 32'd0);
    cycle(1'b0, 0, 0, 1'b1, 70, 1'b0);
    idle(1);
    check("range_rd_err", {31'b0, addr_err}, 32'd1);

    // Randomized traffic
    repeat (400) begin
      int wa, ra;
      wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, HB - 1)) : int'($urandom_range(0, 70));
      ra = int'($urandom_range(0, 70));
      cycle(1'($urandom_range(0, 1)), wa, int'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), ra, 1'b0);
    end
    idle(2);
    check_state("random");

    // Reset in the middle of a clear sweep
    cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
    idle(30);
    do_reset(2);
    check_state("midrst");
    read_all();

    idle(3);
    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
